// File: rtl/pong_pkg.sv
// pong_pkg: shared Pong game state type, signed coordinate type, default geometry and geometry helpers
package pong_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SERVE = 2'd1, PLAY = 2'd2, GAME_OVER = 2'd3} game_state_t;
  typedef logic signed [10:0] s11_t;
  localparam int SCREEN_W_DEF = 640;
  localparam int SCREEN_H_DEF = 480;
  localparam int PADDLE_W_DEF = 10;
  localparam int PADDLE_H_DEF = 50;
  localparam int BALL_SIZE_DEF = 8;
  function automatic s11_t centre(input int span, input int size);
    return s11_t'((span - size) / 2);
  endfunction
  function automatic s11_t limit(input int span, input int size);
    return s11_t'(span - size);
  endfunction
  function automatic s11_t clamp11(input s11_t v, input s11_t lo, input s11_t hi);
    return v < lo ? lo : v > hi ? hi : v;
  endfunction
endpackage

// File: rtl/pong_game_ctrl_tick.sv
// frame_tick_gen: divides CLOCK_50 by TICK_DIV and pulses frame_tick on the last count (CLOCK_50, reset in; frame_tick out)
module frame_tick_gen #(
  parameter int TICK_DIV = 833333
) (
  input  logic CLOCK_50,
  input  logic reset,
  output logic frame_tick
);
  localparam int W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [W-1:0] count;
  assign frame_tick = count == W'(TICK_DIV - 1);
  always_ff @(posedge CLOCK_50)
    count <= reset || frame_tick ? '0 : count + 1'b1;
endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: per-tick Pong sequencer (CLOCK_50, reset, start, paddle buttons in; ball_x/y, p1_y/p2_y, score1/2, game_state, frame_tick out)
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int SCREEN_W    = SCREEN_W_DEF,
  parameter int SCREEN_H    = SCREEN_H_DEF,
  parameter int PADDLE_W    = PADDLE_W_DEF,
  parameter int PADDLE_H    = PADDLE_H_DEF,
  parameter int BALL_SIZE   = BALL_SIZE_DEF,
  parameter int PADDLE_STEP = 4,
  parameter int BALL_VX     = 3,
  parameter int BALL_VY     = 1,
  parameter int TICK_DIV    = 833333,
  parameter int SERVE_TICKS = 60,
  parameter int WIN_SCORE   = 7
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  input  logic       p1_up,
  input  logic       p1_down,
  input  logic       p2_up,
  input  logic       p2_down,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [9:0] p1_y,
  output logic [9:0] p2_y,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [1:0] game_state,
  output logic       frame_tick
);
  localparam s11_t X0   = centre(SCREEN_W, BALL_SIZE);
  localparam s11_t Y0   = centre(SCREEN_H, BALL_SIZE);
  localparam s11_t P0   = centre(SCREEN_H, PADDLE_H);
  localparam s11_t PMAX = limit(SCREEN_H, PADDLE_H);
  localparam s11_t YMAX = limit(SCREEN_H, BALL_SIZE);
  localparam s11_t XL   = s11_t'(PADDLE_W);
  localparam s11_t XR   = limit(SCREEN_W - PADDLE_W, BALL_SIZE);
  localparam s11_t BS   = s11_t'(BALL_SIZE);
  localparam s11_t PH   = s11_t'(PADDLE_H);
  localparam s11_t STEP = s11_t'(PADDLE_STEP);
  localparam s11_t VX   = s11_t'(BALL_VX);
  localparam s11_t VY   = s11_t'(BALL_VY);
  localparam int   SW   = $clog2(SERVE_TICKS + 1);
  game_state_t state, state_n;
  s11_t bx, by, p1, p2, vx, vy, bx_n, by_n, p1_n, p2_n, vx_n, vy_n, nx, ny;
  logic [3:0] s1, s2, s1_n, s2_n;
  logic [SW-1:0] sc, sc_n;
  logic tick, hit1, hit2, miss1, miss2;
  frame_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (.CLOCK_50(CLOCK_50), .reset(reset), .frame_tick(tick));
  assign frame_tick = tick;
  assign ball_x = bx[9:0];
  assign ball_y = by[9:0];
  assign p1_y = p1[9:0];
  assign p2_y = p2[9:0];
  assign score1 = s1;
  assign score2 = s2;
  assign game_state = state;
  function automatic s11_t pad(input s11_t y, input logic up, input logic dn);
    return clamp11(y + (up && !dn ? -STEP : dn && !up ? STEP : 11'sd0), 11'sd0, PMAX);
  endfunction
  always_comb begin
    state_n = state;
    bx_n = bx;
    by_n = by;
    p1_n = p1;
    p2_n = p2;
    vx_n = vx;
    vy_n = vy;
    s1_n = s1;
    s2_n = s2;
    sc_n = sc;
    miss1 = 1'b0;
    miss2 = 1'b0;
    nx = bx + vx;
    ny = by + vy;
    // overlap uses the paddle positions from before this tick's move
    hit1 = by + BS > p1 && by < p1 + PH;
    hit2 = by + BS > p2 && by < p2 + PH;
    if (tick && (state == SERVE || state == PLAY)) begin
      p1_n = pad(p1, p1_up, p1_down);
      p2_n = pad(p2, p2_up, p2_down);
    end
    unique case (state)
      IDLE: state_n = start ? SERVE : IDLE;
      SERVE: if (tick) begin
        sc_n = sc + 1'b1;
        if (sc_n == SW'(SERVE_TICKS)) begin
          sc_n = '0;
          state_n = PLAY;
        end
      end
      PLAY: if (tick) begin
        by_n = clamp11(ny, 11'sd0, YMAX);
        vy_n = ny <= 0 ? VY : ny >= YMAX ? -VY : vy;
        bx_n = nx;
        if (vx < 0 && nx <= XL) begin
          bx_n = XL;
          vx_n = VX;
          miss2 = !hit1;
        end else if (vx > 0 && nx >= XR) begin
          bx_n = XR;
          vx_n = -VX;
          miss1 = !hit2;
        end
        // a miss recentres the ball and serves it toward whoever conceded; vy keeps its sign
        if (miss1 || miss2) begin
          bx_n = X0;
          by_n = Y0;
          vx_n = miss1 ? VX : -VX;
          s1_n = s1 + {3'b0, miss1};
          s2_n = s2 + {3'b0, miss2};
          state_n = s1_n == 4'(WIN_SCORE) || s2_n == 4'(WIN_SCORE) ? GAME_OVER : SERVE;
        end
      end
      GAME_OVER: if (start) begin
        s1_n = '0;
        s2_n = '0;
        p1_n = P0;
        p2_n = P0;
        bx_n = X0;
        by_n = Y0;
        vx_n = VX;
        state_n = SERVE;
      end
    endcase
  end
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state <= IDLE;
      bx <= X0;
      by <= Y0;
      p1 <= P0;
      p2 <= P0;
      vx <= VX;
      vy <= VY;
      s1 <= '0;
      s2 <= '0;
      sc <= '0;
    end else begin
      state <= state_n;
      bx <= bx_n;
      by <= by_n;
      p1 <= p1_n;
      p2 <= p2_n;
      vx <= vx_n;
      vy <= vy_n;
      s1 <= s1_n;
      s2 <= s2_n;
      sc <= sc_n;
    end
  end
endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: directed rally through bounces, walls, scoring, game over and reset with hand-computed positions
module tb_pong_game_ctrl;
  logic CLOCK_50 = 1'b0, reset = 1'b1, start = 1'b0;
  logic p1_up = 1'b0, p1_down = 1'b0, p2_up = 1'b0, p2_down = 1'b0;
  logic [9:0] ball_x, ball_y, p1_y, p2_y;
  logic [3:0] score1, score2;
  logic [1:0] game_state;
  logic frame_tick;
  int vectors = 0, miscompares = 0;
  pong_game_ctrl #(.TICK_DIV(4), .SERVE_TICKS(2), .WIN_SCORE(2)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .start(start),
    .p1_up(p1_up), .p1_down(p1_down), .p2_up(p2_up), .p2_down(p2_down),
    .ball_x(ball_x), .ball_y(ball_y), .p1_y(p1_y), .p2_y(p2_y),
    .score1(score1), .score2(score2), .game_state(game_state), .frame_tick(frame_tick)
  );
  always #5 CLOCK_50 = ~CLOCK_50;
  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic chk_ball(input string tag, input int x, input int y);
    chk({tag, "_x"}, int'(ball_x), x);
    chk({tag, "_y"}, int'(ball_y), y);
  endtask
  task automatic chk_pads(input string tag, input int a, input int b);
    chk({tag, "_p1"}, int'(p1_y), a);
    chk({tag, "_p2"}, int'(p2_y), b);
  endtask
  task automatic chk_game(input string tag, input int st, input int a, input int b);
    chk({tag, "_state"}, int'(game_state), st);
    chk({tag, "_score1"}, int'(score1), a);
    chk({tag, "_score2"}, int'(score2), b);
  endtask
  task automatic chk_reset(input string tag);
    chk_ball(tag, 316, 236);
    chk_pads(tag, 215, 215);
    chk_game(tag, 0, 0, 0);
    chk({tag, "_tick"}, int'(frame_tick), 0);
  endtask
  // returns one cycle after the n-th frame_tick edge, when that tick's update is visible
  task automatic ticks(input int n);
    int w;
    repeat (n) begin
      w = 0;
      while (frame_tick !== 1'b1 && w < 16) begin
        @(negedge CLOCK_50);
        w++;
      end
      assert (w < 16) else begin
        miscompares++;
        $error("FAIL tick_wait: no frame_tick after %0d cycles, required within 4", w);
      end
      @(negedge CLOCK_50);
    end
  endtask
  initial begin
    repeat (3) @(negedge CLOCK_50);
    chk_reset("reset");
    reset = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge CLOCK_50);
      chk("tick_cadence", int'(frame_tick), i % 4 == 3 ? 1 : 0);
    end
    p1_up = 1'b1;
    ticks(2);
    p1_up = 1'b0;
    chk_ball("idle", 316, 236);
    chk_pads("idle", 215, 215);
    chk_game("idle", 0, 0, 0);
    start = 1'b1;
    @(negedge CLOCK_50);
    start = 1'b0;
    chk_game("start", 1, 0, 0);
    ticks(1);
    chk_game("serve1", 1, 0, 0);
    ticks(1);
    chk_game("serve2", 2, 0, 0);
    chk_ball("serve2", 316, 236);
    ticks(1);
    chk_ball("first_play", 319, 237);
    p1_up = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      ticks(1);
      chk("p1_up_sat", int'(p1_y), 215 - 4 * k > 0 ? 215 - 4 * k : 0);
    end
    p1_down = 1'b1;
    ticks(2);
    p1_up = 1'b0;
    p1_down = 1'b0;
    chk("p1_both", int'(p1_y), 0);
    chk_ball("t63", 505, 299);
    ticks(38);
    chk_ball("t101", 619, 337);
    ticks(1);
    chk_game("p2_miss", 1, 1, 0);
    chk_ball("p2_miss", 316, 236);
    p2_down = 1'b1;
    ticks(2);
    chk_game("relaunch", 2, 1, 0);
    chk("p2_down2", int'(p2_y), 223);
    ticks(18);
    p2_down = 1'b0;
    chk("p2_down20", int'(p2_y), 295);
    chk_ball("serve_toward_p2", 370, 254);
    ticks(83);
    chk_ball("pre_bounce_r", 619, 337);
    ticks(1);
    chk_ball("bounce_r", 622, 338);
    p1_down = 1'b1;
    ticks(100);
    p1_down = 1'b0;
    chk("p1_down100", int'(p1_y), 400);
    chk_ball("going_left", 322, 438);
    ticks(33);
    chk_ball("y471", 223, 471);
    ticks(1);
    chk_ball("floor", 220, 472);
    ticks(1);
    chk_ball("after_floor", 217, 471);
    ticks(68);
    chk_ball("pre_bounce_l", 13, 403);
    ticks(1);
    chk_ball("bounce_l", 10, 402);
    p2_up = 1'b1;
    ticks(23);
    p2_up = 1'b0;
    chk("p2_up23", int'(p2_y), 203);
    chk_ball("going_right", 79, 379);
    ticks(180);
    chk_ball("pre_bounce_r2", 619, 199);
    ticks(1);
    chk_ball("bounce_r2", 622, 198);
    p1_up = 1'b1;
    p2_down = 1'b1;
    ticks(60);
    p2_down = 1'b0;
    chk("p2_down_sat", int'(p2_y), 430);
    ticks(40);
    p1_up = 1'b0;
    chk("p1_up100", int'(p1_y), 0);
    chk_ball("rising", 322, 98);
    ticks(97);
    chk_ball("y1", 31, 1);
    ticks(1);
    chk_ball("ceiling", 28, 0);
    ticks(1);
    chk_ball("after_ceiling", 25, 1);
    ticks(4);
    chk_ball("pre_corner_l", 13, 5);
    ticks(1);
    chk_ball("bounce_l2", 10, 6);
    ticks(203);
    chk_ball("pre_win", 619, 209);
    ticks(1);
    chk_game("p1_wins", 3, 2, 0);
    chk_ball("p1_wins", 316, 236);
    p1_down = 1'b1;
    p2_up = 1'b1;
    ticks(2);
    p1_down = 1'b0;
    p2_up = 1'b0;
    chk_pads("over_frozen", 0, 430);
    chk_ball("over_frozen", 316, 236);
    chk_game("over_frozen", 3, 2, 0);
    start = 1'b1;
    @(negedge CLOCK_50);
    start = 1'b0;
    chk_game("restart", 1, 0, 0);
    chk_pads("restart", 215, 215);
    ticks(2);
    chk_game("replay", 2, 0, 0);
    ticks(2);
    chk_ball("replay", 322, 238);
    reset = 1'b1;
    @(negedge CLOCK_50);
    chk_reset("mid_reset");
    reset = 1'b0;
    ticks(2);
    chk_ball("post_reset", 316, 236);
    chk_game("post_reset", 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
